// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line-buffer fetch engine.
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DATA   = 2'd2,
      FINISH = 2'd3
   } fetch_state_t;

   localparam int PIX_640  = 640;
   localparam int PIX_1024 = 1024;

   typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/vga_req_sync.sv
// Brings a fill-request level into sys_clk and produces a one-cycle rising-edge pulse.
module vga_req_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic req,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= SYNC_STAGES'({sync_q, req});
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/vga_line_fetch.sv
// Fetches one video line from the frame buffer in fixed-size bursts and writes
// the returned pixels into the ping-pong line buffer the VGA timing asked for.
module vga_line_fetch
   import vga_pkg::*;
#(
   parameter int                ADDR_W      = 24,
   parameter logic [ADDR_W-1:0] FB_BASE     = '0,
   parameter int                LINE_STRIDE = 1024,
   parameter int                BURST_LEN   = 16,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              vga_mode,
   input  logic              read_buffA_req,
   input  logic              read_buffB_req,
   input  logic [9:0]        read_buff_addr,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_address,
   output logic [4:0]        mem_burstcount,
   input  logic              mem_waitrequest,
   input  rgb565_t           mem_readdata,
   input  logic              mem_readdatavalid,
   output logic              buff_writeA_en,
   output logic              buff_writeB_en,
   output logic [9:0]        buff_write_addr,
   output rgb565_t           buff_write_data,
   output logic              busy,
   output logic              line_late,
   output fetch_state_t      dbg_state
);

   localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);

   fetch_state_t      state;
   logic              target_b;
   logic [10:0]       npix;
   logic [10:0]       pix_cnt;
   logic [BC_W-1:0]   burst_cnt;
   logic              short_fetch;
   logic              lvl_a, lvl_b, rise_a, rise_b;
   logic [ADDR_W-1:0] line_addr;
   logic              more_pix;
   logic              req_held;

   vga_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .req      (read_buffA_req),
      .level    (lvl_a),
      .rise     (rise_a)
   );

   vga_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .req      (read_buffB_req),
      .level    (lvl_b),
      .rise     (rise_b)
   );

   assign line_addr = FB_BASE + ADDR_W'(read_buff_addr) * ADDR_W'(LINE_STRIDE);
   assign more_pix  = (pix_cnt + 11'd1) < npix;
   assign req_held  = target_b ? lvl_b : lvl_a;
   assign dbg_state = state;

   // Memory command handshake: a burst is accepted on a sys_clk edge where
   // mem_read is high and mem_waitrequest is low; address and burstcount are
   // held unchanged from the rise of mem_read until that edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state           <= IDLE;
         target_b        <= 1'b0;
         npix            <= '0;
         pix_cnt         <= '0;
         burst_cnt       <= '0;
         short_fetch     <= 1'b0;
         mem_read        <= 1'b0;
         mem_address     <= '0;
         mem_burstcount  <= '0;
         buff_writeA_en  <= 1'b0;
         buff_writeB_en  <= 1'b0;
         buff_write_addr <= '0;
         buff_write_data <= '0;
         busy            <= 1'b0;
         line_late       <= 1'b0;
      end else begin
         buff_writeA_en <= 1'b0;
         buff_writeB_en <= 1'b0;
         line_late      <= 1'b0;
         case (state)
            IDLE: begin
               if (rise_a || rise_b) begin
                  target_b       <= !rise_a;
                  npix           <= vga_mode ? 11'(PIX_1024) : 11'(PIX_640);
                  pix_cnt        <= '0;
                  short_fetch    <= 1'b0;
                  mem_address    <= line_addr;
                  mem_burstcount <= 5'(BURST_LEN);
                  mem_read       <= 1'b1;
                  busy           <= 1'b1;
                  line_late      <= rise_a && rise_b;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               if (!mem_waitrequest) begin
                  mem_read  <= 1'b0;
                  burst_cnt <= '0;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (mem_readdatavalid) begin
                  buff_writeA_en  <= !target_b;
                  buff_writeB_en  <= target_b;
                  buff_write_addr <= pix_cnt[9:0];
                  buff_write_data <= mem_readdata;
                  pix_cnt         <= pix_cnt + 11'd1;
                  burst_cnt       <= burst_cnt + 1'b1;
                  // Last word of the burst: either chain the next burst or wrap up.
                  if (burst_cnt == BURST_LAST) begin
                     if (more_pix && req_held) begin
                        mem_address <= mem_address + ADDR_W'(BURST_LEN);
                        mem_read    <= 1'b1;
                        state       <= ISSUE;
                     end else begin
                        short_fetch <= more_pix;
                        state       <= FINISH;
                     end
                  end
               end
            end
            FINISH: begin
               busy      <= 1'b0;
               line_late <= short_fetch;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // No queueing: a request edge that arrives mid-fetch is dropped.
         if (state != IDLE && (rise_a || rise_b)) line_late <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a burst memory model and write scoreboard.
module tb_vga_line_fetch;
   import vga_pkg::*;

   localparam int W = 28;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n = 1'b0;
   logic         vga_mode = 1'b0;
   logic         read_buffA_req = 1'b0;
   logic         read_buffB_req = 1'b0;
   logic [9:0]   read_buff_addr = '0;
   logic         mem_read;
   logic [23:0]  mem_address;
   logic [4:0]   mem_burstcount;
   logic         mem_waitrequest = 1'b0;
   logic [15:0]  mem_readdata = '0;
   logic         mem_readdatavalid = 1'b0;
   logic         buff_writeA_en, buff_writeB_en;
   logic [9:0]   buff_write_addr;
   logic [15:0]  buff_write_data;
   logic         busy, line_late;
   fetch_state_t dbg_state;

   int tests = 0;
   int fails = 0;
   logic [W-1:0]  exp_q[$];
   logic [23:0]   addr_q[$];
   int late_cnt = 0;
   int wr_cnt = 0;
   int burst_seen = 0;
   int wait_cycles = 0;

   vga_line_fetch dut (
      .sys_clk          (sys_clk),
      .sys_rst_n        (sys_rst_n),
      .vga_mode         (vga_mode),
      .read_buffA_req   (read_buffA_req),
      .read_buffB_req   (read_buffB_req),
      .read_buff_addr   (read_buff_addr),
      .mem_read         (mem_read),
      .mem_address      (mem_address),
      .mem_burstcount   (mem_burstcount),
      .mem_waitrequest  (mem_waitrequest),
      .mem_readdata     (mem_readdata),
      .mem_readdatavalid(mem_readdatavalid),
      .buff_writeA_en   (buff_writeA_en),
      .buff_writeB_en   (buff_writeB_en),
      .buff_write_addr  (buff_write_addr),
      .buff_write_data  (buff_write_data),
      .busy             (busy),
      .line_late        (line_late),
      .dbg_state        (dbg_state)
   );

   // clock / reset
   always #5 sys_clk = ~sys_clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory model: word at address a holds a[15:0]; optional waits per command.
   logic        acc_q = 1'b0;
   logic        cmd_seen = 1'b0;
   int          ret_left = 0;
   int          wait_left = 0;
   logic [23:0] ret_addr = '0;
   logic [23:0] cmd_addr = '0;

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         mem_waitrequest   = 1'b0;
         mem_readdatavalid = 1'b0;
         acc_q    = 1'b0;
         cmd_seen = 1'b0;
         ret_left = 0;
      end else begin
         if (acc_q) begin
            acc_q    = 1'b0;
            ret_left = int'(mem_burstcount);
            ret_addr = cmd_addr;
         end
         if (ret_left > 0) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = ret_addr[15:0];
            ret_addr++;
            ret_left--;
         end else begin
            mem_readdatavalid = 1'b0;
            mem_readdata      = 16'($urandom_range(0, 65535));
         end
         if (mem_read) begin
            if (!cmd_seen) begin
               logic [31:0] exp_a;
               cmd_seen  = 1'b1;
               cmd_addr  = mem_address;
               wait_left = wait_cycles;
               burst_seen++;
               exp_a = (addr_q.size() > 0) ? {8'h00, addr_q.pop_front()} : 32'hDEAD_0000;
               check("burst_addr", {8'h00, mem_address}, exp_a);
               check("burstcount", {27'h0, mem_burstcount}, 32'd16);
            end else begin
               check("addr_stable", {8'h00, mem_address}, {8'h00, cmd_addr});
            end
            if (wait_left > 0) begin
               mem_waitrequest = 1'b1;
               wait_left--;
            end else begin
               mem_waitrequest = 1'b0;
               acc_q = 1'b1;
            end
         end else begin
            mem_waitrequest = 1'b0;
            cmd_seen = 1'b0;
         end
      end
   end

   // Scoreboard: every write strobe pops one expected {A, B, addr, data}.
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (line_late) late_cnt++;
         if (buff_writeA_en || buff_writeB_en) begin
            logic [31:0] exp_w;
            wr_cnt++;
            exp_w = (exp_q.size() > 0) ? {4'h0, exp_q.pop_front()} : 32'hFFFF_FFFF;
            check("write", {4'h0, buff_writeA_en, buff_writeB_en, buff_write_addr, buff_write_data}, exp_w);
            if (exp_q.size() == 0) check("busy_at_last_write", {31'h0, busy}, 32'd1);
         end
      end
   end

   // driver tasks
   task automatic expect_fill(input logic b, input int line, input int nwords);
      logic [23:0] base;
      base = 24'(line * 1024);
      for (int p = 0; p < nwords; p++) begin
         logic [23:0] a;
         logic [9:0]  pa;
         a  = base + 24'(p);
         pa = 10'(p);
         exp_q.push_back({!b, b, pa, a[15:0]});
      end
      for (int k = 0; k < nwords / 16; k++) addr_q.push_back(base + 24'(k * 16));
   endtask

   task automatic start_test(input int waits);
      @(negedge sys_clk);
      wait_cycles = waits;
      late_cnt    = 0;
      wr_cnt      = 0;
      burst_seen  = 0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0 || dbg_state != IDLE) && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_done_in_budget"}, {31'h0, n < budget}, 32'd1);
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic wait_writes(input int target, input int budget);
      int n;
      n = 0;
      while (wr_cnt < target && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      check("writes_reached", {31'h0, n < budget}, 32'd1);
   endtask

   task automatic end_checks(input string tag, input int bursts, input int writes, input int lates);
      check({tag, "_bursts"}, bursts == 0 ? 32'(burst_seen) : 32'(burst_seen), 32'(bursts));
      check({tag, "_writes"}, 32'(wr_cnt), 32'(writes));
      check({tag, "_line_late"}, 32'(late_cnt), 32'(lates));
      check({tag, "_busy"}, {31'h0, busy}, 32'd0);
      check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Reset with inputs toggling
      repeat (3) @(negedge sys_clk);
      read_buffA_req = 1'b1;
      read_buffB_req = 1'b1;
      vga_mode       = 1'b1;
      read_buff_addr = 10'h155;
      repeat (5) @(negedge sys_clk);
      check("rst_mem_read", {31'h0, mem_read}, 32'd0);
      check("rst_mem_address", {8'h0, mem_address}, 32'd0);
      check("rst_burstcount", {27'h0, mem_burstcount}, 32'd0);
      check("rst_write_en", {30'h0, buff_writeA_en, buff_writeB_en}, 32'd0);
      check("rst_write_addr_data", {6'h0, buff_write_addr, buff_write_data}, 32'd0);
      check("rst_busy_late", {30'h0, busy, line_late}, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      read_buffA_req = 1'b0;
      read_buffB_req = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (8) @(negedge sys_clk);
      check("post_rst_busy", {31'h0, busy}, 32'd0);
      check("post_rst_mem_read", {31'h0, mem_read}, 32'd0);
      check("post_rst_state", 32'(dbg_state), 32'(IDLE));

      // Mode 0 fill of A, line 5, no waits
      start_test(0);
      expect_fill(1'b0, 5, 640);
      vga_mode = 1'b0;
      read_buff_addr = 10'd5;
      read_buffA_req = 1'b1;
      repeat (5) @(negedge sys_clk);
      check("busy_rises", {31'h0, busy}, 32'd1);
      wait_done("fill_a", 3000);
      end_checks("fill_a", 40, 640, 0);
      read_buffA_req = 1'b0;
      repeat (5) @(negedge sys_clk);

      // Mode 1 fill of B, line 767, three waitstates per command
      start_test(3);
      expect_fill(1'b1, 767, 1024);
      vga_mode = 1'b1;
      read_buff_addr = 10'd767;
      read_buffB_req = 1'b1;
      wait_done("fill_b", 6000);
      end_checks("fill_b", 64, 1024, 0);
      read_buffB_req = 1'b0;
      repeat (5) @(negedge sys_clk);

      // Early drop after 200 words: burst 13 completes, nothing further
      start_test(0);
      expect_fill(1'b0, 100, 208);
      vga_mode = 1'b1;
      read_buff_addr = 10'd100;
      read_buffA_req = 1'b1;
      wait_writes(200, 3000);
      read_buffA_req = 1'b0;
      wait_done("early_drop", 500);
      end_checks("early_drop", 13, 208, 1);

      // Collision of A and B, then a second B edge while busy
      start_test(0);
      expect_fill(1'b0, 3, 640);
      vga_mode = 1'b0;
      read_buff_addr = 10'd3;
      read_buffA_req = 1'b1;
      read_buffB_req = 1'b1;
      wait_writes(100, 1000);
      read_buffB_req = 1'b0;
      repeat (6) @(negedge sys_clk);
      read_buffB_req = 1'b1;
      wait_done("collision", 3000);
      end_checks("collision", 40, 640, 2);
      read_buffA_req = 1'b0;
      read_buffB_req = 1'b0;
      repeat (5) @(negedge sys_clk);

      // Asynchronous reset during burst 3, then a clean fill
      start_test(0);
      expect_fill(1'b0, 9, 640);
      vga_mode = 1'b0;
      read_buff_addr = 10'd9;
      read_buffA_req = 1'b1;
      wait_writes(40, 1000);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("async_rst_mem_read", {31'h0, mem_read}, 32'd0);
      check("async_rst_write_en", {30'h0, buff_writeA_en, buff_writeB_en}, 32'd0);
      check("async_rst_busy", {31'h0, busy}, 32'd0);
      check("async_rst_state", 32'(dbg_state), 32'(IDLE));
      exp_q.delete();
      addr_q.delete();
      read_buffA_req = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      start_test(0);
      expect_fill(1'b0, 2, 640);
      read_buff_addr = 10'd2;
      read_buffA_req = 1'b1;
      wait_done("after_rst", 3000);
      end_checks("after_rst", 40, 640, 0);
      read_buffA_req = 1'b0;
      repeat (5) @(negedge sys_clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
